// File: rtl/btb_update_sched.sv
// btb_update_sched: buffers EX/ID BTB update requests in per-source FIFOs and issues one registered op per cycle.
// Optional macro BTB_UPD_BYPASS_EN: an idle-path bypass that skips the FIFOs for latency 1.
module btb_update_sched #(
    parameter int FIFO_DEPTH = 4,
    parameter int IDX_W      = 5,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [31:0]       ex_pc,
    input  logic [IDX_W-1:0]  ex_index,
    input  logic [2:0]        ex_op,
    input  logic              ex_orien,
    input  logic [31:0]       ex_target,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [31:0]       id_pc,
    input  logic [IDX_W-1:0]  id_index,
    input  logic [2:0]        id_op,
    input  logic [31:0]       id_target,
    input  logic              id_push,
    input  logic              id_pop,
    input  logic              flush,
    output logic              operate_en,
    output logic [31:0]       operate_pc,
    output logic [IDX_W-1:0]  operate_index,
    output logic              add_entry,
    output logic              delete_entry,
    output logic              target_error,
    output logic              pre_right,
    output logic              pre_error,
    output logic              right_orien,
    output logic [31:0]       right_target,
    output logic              push_ras,
    output logic              pop_ras,
    output logic              err_illegal_op
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [PTR_W:0]   PTR_ONE = (PTR_W + 1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef struct packed {
        logic [31:0]      pc;
        logic [IDX_W-1:0] index;
        logic [2:0]       op;
        logic             orien;
        logic [31:0]      target;
        logic             push;
        logic             pop;
    } req_t;

    req_t ex_mem [FIFO_DEPTH];
    req_t id_mem [FIFO_DEPTH];

    logic [PTR_W:0]   ex_wp, ex_rp, id_wp, id_rp;
    logic [CNT_W-1:0] starve_cnt;
    logic             ready_en;
    logic             ex_empty, ex_full, id_empty, id_full;
    logic             ex_acc, id_acc, ex_byp, id_byp, ex_wr, id_wr;
    logic             grant_ex, grant_id;
    req_t             ex_req, id_req, sel;
    logic             sel_valid, sel_id, sel_legal, issue, illegal;

    assign ex_empty = (ex_wp == ex_rp);
    assign id_empty = (id_wp == id_rp);
    assign ex_full  = (ex_wp[PTR_W] != ex_rp[PTR_W]) && (ex_wp[PTR_W-1:0] == ex_rp[PTR_W-1:0]);
    assign id_full  = (id_wp[PTR_W] != id_rp[PTR_W]) && (id_wp[PTR_W-1:0] == id_rp[PTR_W-1:0]);

    // ready_en keeps both ready outputs low until the first clock after reset release
    assign ex_ready = ready_en && !ex_full;
    assign id_ready = ready_en && !id_full;
    assign ex_acc   = ex_valid && ex_ready;
    assign id_acc   = id_valid && id_ready && !flush;

    assign ex_req = '{pc: ex_pc, index: ex_index, op: ex_op, orien: ex_orien,
                      target: ex_target, push: 1'b0, pop: 1'b0};
    assign id_req = '{pc: id_pc, index: id_index, op: id_op, orien: 1'b0,
                      target: id_target, push: id_push, pop: id_pop};

`ifdef BTB_UPD_BYPASS_EN
    logic byp_ok;
    assign byp_ok = ex_empty && id_empty && !operate_en;
    assign ex_byp = byp_ok && ex_acc;
    assign id_byp = byp_ok && id_acc && !ex_acc;
`else
    assign ex_byp = 1'b0;
    assign id_byp = 1'b0;
`endif

    assign ex_wr    = ex_acc && !ex_byp;
    assign id_wr    = id_acc && !id_byp;
    assign grant_id = !id_empty && (ex_empty || starve_cnt == CNT_MAX);
    assign grant_ex = !ex_empty && !grant_id;

    always_comb begin
        sel       = '0;
        sel_valid = 1'b0;
        sel_id    = 1'b0;
        if (grant_ex) begin
            sel       = ex_mem[ex_rp[PTR_W-1:0]];
            sel_valid = 1'b1;
        end else if (grant_id) begin
            sel       = id_mem[id_rp[PTR_W-1:0]];
            sel_valid = 1'b1;
            sel_id    = 1'b1;
        end else if (ex_byp) begin
            sel       = ex_req;
            sel_valid = 1'b1;
        end else if (id_byp) begin
            sel       = id_req;
            sel_valid = 1'b1;
            sel_id    = 1'b1;
        end
    end

    // Op 000 is a RAS-only request and only meaningful from the ID side
    always_comb begin
        sel_legal = 1'b0;
        case (sel.op)
            3'b000:                                 sel_legal = sel_id;
            3'b001, 3'b010, 3'b011, 3'b100, 3'b101: sel_legal = 1'b1;
            default:                                sel_legal = 1'b0;
        endcase
    end

    assign issue   = sel_valid && !(sel_id && flush) && sel_legal;
    assign illegal = sel_valid && !(sel_id && flush) && !sel_legal;

    always_ff @(posedge clk) begin
        if (ex_wr) ex_mem[ex_wp[PTR_W-1:0]] <= ex_req;
        if (id_wr) id_mem[id_wp[PTR_W-1:0]] <= id_req;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ex_wp    <= '0;
            ex_rp    <= '0;
            id_wp    <= '0;
            id_rp    <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (ex_wr)    ex_wp <= ex_wp + PTR_ONE;
            if (grant_ex) ex_rp <= ex_rp + PTR_ONE;
            if (id_wr)    id_wp <= id_wp + PTR_ONE;
            if (flush)
                id_rp <= id_wp;
            else if (grant_id)
                id_rp <= id_rp + PTR_ONE;
        end
    end

    // Counts EX grants taken while ID waits; reaching STARVE_MAX hands the next slot to ID
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            starve_cnt <= '0;
        else if (grant_id || id_empty || flush)
            starve_cnt <= '0;
        else if (grant_ex && starve_cnt != CNT_MAX)
            starve_cnt <= starve_cnt + CNT_ONE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            operate_en     <= 1'b0;
            operate_pc     <= '0;
            operate_index  <= '0;
            add_entry      <= 1'b0;
            delete_entry   <= 1'b0;
            target_error   <= 1'b0;
            pre_right      <= 1'b0;
            pre_error      <= 1'b0;
            right_orien    <= 1'b0;
            right_target   <= '0;
            push_ras       <= 1'b0;
            pop_ras        <= 1'b0;
            err_illegal_op <= 1'b0;
        end else begin
            operate_en     <= issue;
            operate_pc     <= issue ? sel.pc : '0;
            operate_index  <= issue ? sel.index : '0;
            add_entry      <= issue && (sel.op == 3'b001);
            delete_entry   <= issue && (sel.op == 3'b010);
            target_error   <= issue && (sel.op == 3'b011);
            pre_right      <= issue && (sel.op == 3'b100);
            pre_error      <= issue && (sel.op == 3'b101);
            right_orien    <= issue && sel.orien;
            right_target   <= issue ? sel.target : '0;
            push_ras       <= issue && sel.push;
            pop_ras        <= issue && sel.pop;
            err_illegal_op <= err_illegal_op || illegal;
        end
    end

endmodule
